// File: rtl/iter_muldiv_pkg.sv
// Shared types and operation-decode helpers for the iterative RV32M multiply/divide unit.
package iter_muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_func_t f);
        return f inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic a_signed(input muldiv_func_t f);
        return f inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic b_signed(input muldiv_func_t f);
        return f inside {MUL, MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared hi/lo shift datapath: one shift-add (multiply) or restoring shift-subtract
// (divide) step per enabled cycle on unsigned magnitudes.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] init_lo,
    input  logic [WIDTH-1:0] init_m,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH:0]   trial;

    // Multiply: {hi,lo} = {partial product, remaining multiplier bits}.
    // Divide:   {hi,lo} = {partial remainder, dividend bits / quotient bits}.
    always_comb begin
        sum     = {1'b0, hi} + {1'b0, m};
        rem_s   = {hi, lo[WIDTH-1]};
        trial   = rem_s - {1'b0, m};
        hi_next = hi;
        lo_next = lo;
        if (div_mode) begin
            if (!trial[WIDTH]) begin
                hi_next = trial[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = rem_s[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end else if (lo[0]) begin
            {hi_next, lo_next} = {sum, lo[WIDTH-1:1]};
        end else begin
            {hi_next, lo_next} = {1'b0, hi, lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            hi <= '0;
            lo <= init_lo;
            m  <= init_m;
        end else if (step) begin
            hi <= hi_next;
            lo <= lo_next;
        end
    end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with START/BUSY/DONE handshake.
// Define ITER_MULDIV_FAST_PATH_EN to finish trivial operations in one CALC-free cycle.
module iter_muldiv_unit
    import iter_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       FUNC,
    input  logic [WIDTH-1:0] SRC_A,
    input  logic [WIDTH-1:0] SRC_B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    muldiv_state_t    state, state_next;
    logic [CNT_W-1:0] cnt;
    muldiv_func_t     func_in, func;
    logic             accept, a_neg, b_neg, div_zero, sgn_ovf, special_in, fast_in;
    logic [WIDTH-1:0] a_mag, b_mag, special_val, init_lo, init_m;
    logic             neg_res, neg_rem, special;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH-1:0] hi_next, lo_next, calc_res;
    logic [2*WIDTH-1:0] prod;

    // Incoming operation decode, only meaningful in the accept cycle
    always_comb begin
        func_in     = muldiv_func_t'(FUNC);
        a_neg       = a_signed(func_in) && SRC_A[WIDTH-1];
        b_neg       = b_signed(func_in) && SRC_B[WIDTH-1];
        a_mag       = cond_neg(SRC_A, a_neg);
        b_mag       = cond_neg(SRC_B, b_neg);
        div_zero    = is_div(func_in) && (SRC_B == '0);
        sgn_ovf     = (func_in == DIV || func_in == REM) && (SRC_A == MIN_NEG) && (SRC_B == '1);
        special_in  = div_zero || sgn_ovf;
        special_val = '0;
        if (div_zero) begin
            special_val = (func_in inside {REM, REMU}) ? SRC_A : '1;
        end else if (sgn_ovf) begin
            special_val = (func_in == DIV) ? SRC_A : '0;
        end
`ifdef ITER_MULDIV_FAST_PATH_EN
        fast_in = special_in || (!is_div(func_in) && (SRC_A == '0 || SRC_B == '0));
`else
        fast_in = 1'b0;
`endif
        init_lo = is_div(func_in) ? a_mag : b_mag;
        init_m  = is_div(func_in) ? b_mag : a_mag;
    end

    assign accept = START && (state == IDLE || state == FIN);

    always_comb begin
        state_next = state;
        BUSY       = (state != IDLE);
        DONE       = (state == FIN);
        case (state)
            IDLE, FIN: begin
                if (START) state_next = fast_in ? FIN : CALC;
                else       state_next = IDLE;
            end
            CALC:    if (cnt == '0) state_next = FIN;
            default: state_next = IDLE;
        endcase
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (CLK),
        .load     (accept),
        .step     (state == CALC),
        .div_mode (is_div(func)),
        .init_lo  (init_lo),
        .init_m   (init_m),
        .hi_next  (hi_next),
        .lo_next  (lo_next)
    );

    // Result select works on the core's last-step values so RESULT lands on the FIN entry edge
    always_comb begin
        prod = cond_neg2({hi_next, lo_next}, neg_res);
        case (func)
            MUL:                 calc_res = prod[WIDTH-1:0];
            MULH, MULHSU, MULHU: calc_res = prod[2*WIDTH-1:WIDTH];
            DIV, DIVU:           calc_res = cond_neg(lo_next, neg_res);
            default:             calc_res = cond_neg(hi_next, neg_rem);
        endcase
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            func        <= func_in;
            neg_res     <= a_neg ^ b_neg;
            neg_rem     <= a_neg;
            special     <= special_in;
            special_res <= special_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            RESULT <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= CNT_W'(WIDTH-1);
                if (fast_in) RESULT <= special_val;
            end else if (state == CALC) begin
                if (cnt != '0) cnt <= cnt - CNT_W'(1);
                else           RESULT <= special ? special_res : calc_res;
            end
        end
    end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Scoreboard bench for iter_muldiv_unit: arithmetic reference model, decoupled DONE monitor.
module tb_iter_muldiv_unit;

    localparam int W = 32;
`ifdef ITER_MULDIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST, START;
    logic [2:0]   FUNC;
    logic [W-1:0] SRC_A, SRC_B;
    logic         BUSY, DONE;
    logic [W-1:0] RESULT;

    iter_muldiv_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .FUNC(FUNC),
        .SRC_A(SRC_A), .SRC_B(SRC_B), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] res;
        int           due;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_due = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0]     ea, eb;
        logic signed [2*W+1:0] p;
        longint                la, lb;
        logic                  sgn;
        ea  = (f <= 3'd2) ? $signed({a[W-1], a}) : $signed({1'b0, a});
        eb  = (f <= 3'd1) ? $signed({b[W-1], b}) : $signed({1'b0, b});
        p   = ea * eb;
        sgn = (f == 3'd4 || f == 3'd6);
        la  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        lb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        case (f)
            3'd0:             return p[W-1:0];
            3'd1, 3'd2, 3'd3: return p[2*W-1:W];
            default: begin
                if (lb == 0) return (f == 3'd4 || f == 3'd5) ? {W{1'b1}} : a;
                if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (f == 3'd4) ? a : '0;
                if (f == 3'd4 || f == 3'd5) return W'(la / lb);
                return W'(la % lb);
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic trivial;
        if (f >= 3'd4)
            trivial = (b == '0) || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == '1);
        else
            trivial = (a == '0) || (b == '0);
        return (FAST && trivial) ? 1 : W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 in a cycle where the DUT is IDLE or FIN; returns one cycle later.
    task automatic start_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        exp_t e;
        FUNC   = f;
        SRC_A  = a;
        SRC_B  = b;
        START  = 1'b1;
        e.res  = ref_model(f, a, b);
        e.due  = cyc + latency(f, a, b);
        e.name = name;
        sb.push_back(e);
        last_due = e.due;
        @(posedge CLK); #1;
        START = 1'b0;
        FUNC  = 3'($urandom);
        SRC_A = $urandom;
        SRC_B = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge CLK); #1;
    endtask

    always @(negedge CLK) begin
        if (DONE) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: DONE=1 in cycle %0d with RESULT 0x%0h, required no DONE", cyc, RESULT);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, " result"}, 64'(RESULT), 64'(e.res));
                check({e.name, " done_cycle"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        RST = 1'b1; START = 1'b0; FUNC = '0; SRC_A = '0; SRC_B = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", 64'(BUSY), 64'(0));
        check("reset_done", 64'(DONE), 64'(0));
        check("reset_result", 64'(RESULT), 64'(0));
        RST = 1'b0;
        @(posedge CLK); #1;

        start_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
        check("mul_busy_c1", 64'(BUSY), 64'(1));
        repeat (31) @(posedge CLK);
        #1;
        check("mul_busy_c32", 64'(BUSY), 64'(1));
        check("mul_done_c32", 64'(DONE), 64'(0));
        wait_idle();
        check("idle_busy", 64'(BUSY), 64'(0));

        start_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min_sq");  wait_idle();
        start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max_sq"); wait_idle();
        start_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");    wait_idle();
        start_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_-7_2");             wait_idle();
        start_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_-7_2");             wait_idle();
        start_op(3'd7, 32'd7, 32'd2, "remu_7_2");
        while (cyc < last_due) begin @(posedge CLK); #1; end
        start_op(3'd5, 32'd7, 32'd2, "divu_7_2_b2b");
        wait_idle();

        start_op(3'd4, 32'd5, 32'd0, "div_5_0");                      wait_idle();
        start_op(3'd6, 32'd5, 32'd0, "rem_5_0");                      wait_idle();
        start_op(3'd6, 32'hFFFF_FFF9, 32'd0, "rem_-7_0");             wait_idle();
        start_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");      wait_idle();
        start_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");      wait_idle();
        start_op(3'd0, 32'd0, 32'h1234_5678, "mul_zero");             wait_idle();

        // A START pulse mid-operation must be ignored
        start_op(3'd5, 32'd100, 32'd7, "divu_ignored_start");
        repeat (4) @(posedge CLK);
        #1;
        START = 1'b1; FUNC = 3'd0; SRC_A = $urandom; SRC_B = $urandom;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_idle();

        // Abort mid-CALC: RESULT holds 14 from the previous op until reset clears it
        start_op(3'd0, 32'd123, 32'd456, "mul_aborted");
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b1;
        sb.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_busy", 64'(BUSY), 64'(0));
        check("abort_result", 64'(RESULT), 64'(0));
        check("abort_done", 64'(DONE), 64'(0));
        repeat (40) @(posedge CLK);
        #1;

        for (int i = 0; i < 60; i++) begin
            start_op(3'($urandom_range(0, 7)), pick(), pick(), $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) begin
                while (cyc < last_due) begin @(posedge CLK); #1; end
            end else begin
                wait_idle();
            end
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
